pio_access_arbiter: RTL
=======================

# pio_access_arbiter

Round-robin arbiter that shares the single Avalon-MM slave port of the 8-bit output PIO (the LED/status port of the breakout/Tetris system) between several on-chip requesters, e.g. game logic, a debug/UART bridge and an LED animator. Each requester issues one read or write at a time over a valid/ready command handshake and gets a one-cycle response pulse. The block is the only master that drives the PIO's address/chipselect/write_n/writedata and samples its readdata.

## Interface
- NUM_REQ, 3, number of requesters (2..8); IDX_W = clog2(NUM_REQ), minimum 1
- ADDR_W, 2, PIO register address width
- DATA_W, 32, Avalon data width
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  reset; one clock; asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester command accept (one-hot or zero)
- req_write  in  NUM_REQ  1 = write, 0 = read, per requester
- req_address  in  NUM_REQ*ADDR_W  packed; requester i at [i*ADDR_W +: ADDR_W]
- req_writedata  in  NUM_REQ*DATA_W  packed; requester i at [i*DATA_W +: DATA_W]
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
- rsp_readdata  out  DATA_W  shared read result, valid while any rsp_valid bit is high
- grant_id  out  IDX_W  index of the current/last owner (debug)
- address  out  ADDR_W  to PIO
- chipselect  out  1  to PIO
- write_n  out  1  to PIO, active-low write strobe
- writedata  out  DATA_W  to PIO
- readdata  in  DATA_W  from PIO (combinational in the PIO)

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: if any req_valid, choose the winner by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap. Assert req_ready[winner] combinationally in this cycle only; latch write, address and writedata of the winner; set grant_id = winner; go to ACCESS. If no req_valid, stay in IDLE with req_ready = 0.
- ACCESS (exactly one cycle): chipselect = 1, address/writedata from the latched values, write_n = ~latched write. On a read, capture readdata into rsp_readdata at the end of the cycle. On a write, rsp_readdata is left unchanged. Go to RESP.
- RESP (one cycle): rsp_valid[grant_id] = 1. Writes are acknowledged the same way as reads. Update last_grant = grant_id. Go to IDLE.
- req_ready is never asserted outside IDLE. Requests arriving in ACCESS/RESP wait.
- Requester rules: hold req_valid and the payload stable until req_ready. Payload is sampled only in the handshake cycle. Dropping valid before ready is legal and leaves no side effect.
- Out-of-range address (e.g. 1..3 on the PIO) is forwarded unchanged. Writes are ignored by the PIO, and reads return whatever the PIO drives (0).
- NUM_REQ not a power of two: wrap from NUM_REQ-1 to 0 and never select an index ≥ NUM_REQ.

## Timing
- Reset values: chipselect 0, write_n 1, address 0, writedata 0, rsp_valid 0, rsp_readdata 0, grant_id 0, req_ready 0, last_grant NUM_REQ-1 (requester 0 has first priority).
- Handshake at cycle T → chipselect high in T+1 → rsp_valid in T+2. Next grant possible at T+3, so peak throughput is 1 access per 3 cycles.
- chipselect is high for exactly one cycle per access. write_n is 1 whenever chipselect is 0.
- PIO register update is visible on out_port at T+2 (written on the edge that ends ACCESS).
- Async reset mid-operation: all outputs return to reset values immediately and the FSM goes to IDLE. The in-flight access is dropped with no rsp_valid. Requesters must re-issue.
- Fairness: with all requesters continuously valid, each is granted once per NUM_REQ grants.

## Test plan
- Single write: req0 writes addr 0, data 0x000000A5 → req_ready[0] for 1 cycle, chipselect/write_n=0 next cycle, rsp_valid[0] at T+2, PIO out_port = 0xA5.
- Read-back: req1 reads addr 0 after the above → write_n stays 1, rsp_valid[1] at T+2 with rsp_readdata = 0x000000A5. rsp_valid[0] and rsp_valid[2] stay 0.
- Contention: req0/1/2 valid every cycle from reset → grant order 0,1,2,0,1,… with handshakes exactly 3 cycles apart. grant_id matches.
- Wrap and skip: last_grant=2, only req1 valid → req1 granted at once. Then req0 and req1 both valid → req0 wins next.
- Unmapped address: req2 writes addr 1, data 0xFF → out_port unchanged; reading addr 1 returns 0. Each access still completes with rsp_valid.
- Reset mid-access: assert reset_n=0 during ACCESS → chipselect 0 and write_n 1 immediately, no rsp_valid. After release, requester 0 has priority and a re-issued write completes normally.

Source files
------------

// File: rtl/pio_access_arbiter.sv
// Round-robin arbiter sharing the single Avalon-MM slave port of the output PIO
// between NUM_REQ requesters; one access per three cycles, one response pulse each.
module pio_access_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  localparam int IDX_W  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_readdata,
  output logic [IDX_W-1:0]          grant_id,
  output logic [ADDR_W-1:0]         address,
  output logic                      chipselect,
  output logic                      write_n,
  output logic [DATA_W-1:0]         writedata,
  input  logic [DATA_W-1:0]         readdata
);

  localparam int unsigned NREQ = NUM_REQ;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] winner;
  logic             found;
  int unsigned      idx;

  // Search starts just after the last owner and wraps at NUM_REQ, so indices
  // beyond NUM_REQ-1 are never produced even when NUM_REQ is not a power of two.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = k + 32'(last_grant);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[IDX_W'(idx)]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && state == IDLE && found) req_ready[winner] = 1'b1;
  end

  // The PIO-side registers double as the latched command; write_n therefore
  // also tells the ACCESS cycle whether to capture readdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      chipselect   <= 1'b0;
      write_n      <= 1'b1;
      address      <= '0;
      writedata    <= '0;
      rsp_valid    <= '0;
      rsp_readdata <= '0;
      grant_id     <= '0;
      last_grant   <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id   <= winner;
            address    <= req_address[winner*ADDR_W +: ADDR_W];
            writedata  <= req_writedata[winner*DATA_W +: DATA_W];
            write_n    <= ~req_write[winner];
            chipselect <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          chipselect          <= 1'b0;
          write_n             <= 1'b1;
          if (write_n) rsp_readdata <= readdata;
          rsp_valid[grant_id] <= 1'b1;
          state               <= RESP;
        end
        RESP: begin
          rsp_valid  <= '0;
          last_grant <= grant_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
